// File: rtl/sf48_pkg.sv
// Shared widths, saturation limits and phase-state encoding for the
// 48 kHz stereo matrix / scale-factor stage.
package sf48_pkg;

    localparam int DW      = 18;       // audio sample and output width
    localparam int KW      = 4;        // scale-factor width (unsigned Q1.3)
    localparam int SUMW    = 19;       // L+R / L-R width, cannot overflow
    localparam int PRODW   = 24;       // 19-bit signed x 5-bit signed product
    localparam int SHIFT   = 4;        // /2 matrix gain combined with /8 Q1.3
    localparam int SAT_MAX = 131071;   // largest 18-bit signed value
    localparam int SAT_MIN = -131072;  // smallest 18-bit signed value

    // Phase of the sample period the datapath is working on.
    typedef enum logic [2:0] {
        CAPTURE = 3'd0,
        MUL_P   = 3'd1,
        OUT_P   = 3'd2,
        OUT_M   = 3'd3,
        IDLE    = 3'd4
    } state_t;

endpackage

// File: rtl/block_sf_48_withoutround_scale.sv
// Combinational scale stage: signed sum/difference times an unsigned
// Q1.3 factor, arithmetic shift right (floor, no rounding) and clamp to
// the 18-bit signed range.
module sf_scale_trunc
    import sf48_pkg::*;
(
    input  logic signed [SUMW-1:0] a,
    input  logic        [KW-1:0]   k,
    output logic signed [DW-1:0]   y
);

    logic signed [PRODW-1:0] a_ext;
    logic signed [PRODW-1:0] k_ext;
    logic signed [PRODW-1:0] prod;
    logic signed [PRODW-1:0] shifted;

    // Multiply with the factor zero-extended, floor-shift, then saturate.
    always_comb begin
        a_ext   = PRODW'(a);
        k_ext   = $signed({{(PRODW-KW){1'b0}}, k});
        prod    = a_ext * k_ext;
        shifted = prod >>> SHIFT;
        if (shifted > PRODW'(SAT_MAX)) begin
            y = DW'(SAT_MAX);
        end else if (shifted < PRODW'(SAT_MIN)) begin
            y = DW'(SAT_MIN);
        end else begin
            y = shifted[DW-1:0];
        end
    end

endmodule

// File: rtl/block_sf_48_withoutround.sv
// Stereo matrix and scale-factor stage. Once per SAMPLE_PERIOD cycles it
// captures LEFT/RIGHT and the two scale factors, then reuses a single
// scale unit for the sum path (result two edges after capture) and the
// difference path (three edges after capture).
//
// Handshake: ready_out_LpR / ready_out_LmR are single-cycle strobes with no
// back-pressure; the matching LI_in_* output is new in exactly the cycle its
// strobe is high and holds its value until the next strobe. The two strobes
// are never high together.
module block_sf_48_withoutround
    import sf48_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic signed [17:0]   LEFT,
    input  logic signed [17:0]   RIGHT,
    input  logic        [3:0]    Ks,
    input  logic        [3:0]    Kd,
    output logic signed [17:0]   LI_in_LpR,
    output logic signed [17:0]   LI_in_LmR,
    output logic                 ready_out_LpR,
    output logic                 ready_out_LmR,
    output logic        [2:0]    fsm_state
);

    localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    state_t                state;
    state_t                state_nxt;

    logic signed [SUMW-1:0] s_q;
    logic signed [SUMW-1:0] d_q;
    logic        [KW-1:0]   ks_q;
    logic        [KW-1:0]   kd_q;
    logic signed [DW-1:0]   p_q;
    logic signed [DW-1:0]   m_q;

    logic signed [SUMW-1:0] op_a;
    logic        [KW-1:0]   op_k;
    logic signed [DW-1:0]   scaled;

    assign fsm_state = state;

    // Next phase count and the phase state that goes with it.
    always_comb begin
        cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        state_nxt = IDLE;
        case (cnt_nxt)
            CW'(0):  state_nxt = CAPTURE;
            CW'(1):  state_nxt = MUL_P;
            CW'(2):  state_nxt = OUT_P;
            CW'(3):  state_nxt = OUT_M;
            default: state_nxt = IDLE;
        endcase
    end

    // Steer the shared scale unit: sum path in MUL_P, difference path otherwise.
    always_comb begin
        op_a = d_q;
        op_k = kd_q;
        if (state == MUL_P) begin
            op_a = s_q;
            op_k = ks_q;
        end
    end

    sf_scale_trunc u_scale (
        .a (op_a),
        .k (op_k),
        .y (scaled)
    );

    // Phase sequencer with registered datapath, outputs and strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            state         <= CAPTURE;
            s_q           <= '0;
            d_q           <= '0;
            ks_q          <= '0;
            kd_q          <= '0;
            p_q           <= '0;
            m_q           <= '0;
            LI_in_LpR     <= '0;
            LI_in_LmR     <= '0;
            ready_out_LpR <= 1'b0;
            ready_out_LmR <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            state         <= state_nxt;
            ready_out_LpR <= 1'b0;
            ready_out_LmR <= 1'b0;
            case (state)
                CAPTURE: begin
                    s_q  <= {LEFT[17], LEFT} + {RIGHT[17], RIGHT};
                    d_q  <= {LEFT[17], LEFT} - {RIGHT[17], RIGHT};
                    ks_q <= Ks;
                    kd_q <= Kd;
                end
                MUL_P: begin
                    p_q <= scaled;
                end
                OUT_P: begin
                    LI_in_LpR     <= p_q;
                    ready_out_LpR <= 1'b1;
                    m_q           <= scaled;
                end
                OUT_M: begin
                    LI_in_LmR     <= m_q;
                    ready_out_LmR <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_sf_48_withoutround.sv
// Directed bench for the stereo matrix / scale-factor stage.
module tb_block_sf_48_withoutround;
    import sf48_pkg::*;

    localparam int SP = 8;

    logic               clock;
    logic               reset;
    logic signed [17:0] LEFT;
    logic signed [17:0] RIGHT;
    logic        [3:0]  Ks;
    logic        [3:0]  Kd;
    logic signed [17:0] LI_in_LpR;
    logic signed [17:0] LI_in_LmR;
    logic               ready_out_LpR;
    logic               ready_out_LmR;
    logic        [2:0]  fsm_state;

    int checks;
    int errors;
    int last_p;
    int last_m;

    block_sf_48_withoutround #(.SAMPLE_PERIOD(SP)) dut (
        .clock         (clock),
        .reset         (reset),
        .LEFT          (LEFT),
        .RIGHT         (RIGHT),
        .Ks            (Ks),
        .Kd            (Kd),
        .LI_in_LpR     (LI_in_LpR),
        .LI_in_LmR     (LI_in_LmR),
        .ready_out_LpR (ready_out_LpR),
        .ready_out_LmR (ready_out_LmR),
        .fsm_state     (fsm_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample period starting from a negedge in the capture phase.
    // Returns at the negedge of the next capture phase.
    task automatic run_sample(input string tag, input int l, input int r,
                              input int ks, input int kd,
                              input int exp_p, input int exp_m,
                              input bit scramble, input bit abort);
        LEFT  = 18'(l);
        RIGHT = 18'(r);
        Ks    = 4'(ks);
        Kd    = 4'(kd);
        @(posedge clock); #1;                       // capture edge
        check({tag, " st_mul"}, int'(fsm_state), int'(MUL_P));
        check({tag, " rdy_p_e0"}, int'(ready_out_LpR), 0);
        if (scramble) begin
            LEFT  = 18'(1000);
            RIGHT = 18'(-5000);
            Ks    = 4'd15;
            Kd    = 4'd15;
        end
        @(posedge clock); #1;                       // product registered
        check({tag, " rdy_p_e1"}, int'(ready_out_LpR), 0);
        check({tag, " hold_p_e1"}, int'(LI_in_LpR), last_p);
        if (scramble) begin
            LEFT  = 18'(-7);
            RIGHT = 18'(77);
            Ks    = 4'd1;
            Kd    = 4'd2;
        end
        @(posedge clock); #1;                       // LpR out
        check({tag, " rdy_p"}, int'(ready_out_LpR), 1);
        check({tag, " rdy_m_e2"}, int'(ready_out_LmR), 0);
        check({tag, " lpr"}, int'(LI_in_LpR), exp_p);
        check({tag, " hold_m_e2"}, int'(LI_in_LmR), last_m);
        last_p = exp_p;
        if (abort) begin
            #2 reset = 1'b1;
            #1;
            check({tag, " rst_lpr"}, int'(LI_in_LpR), 0);
            check({tag, " rst_lmr"}, int'(LI_in_LmR), 0);
            check({tag, " rst_rdy_p"}, int'(ready_out_LpR), 0);
            last_p = 0;
            last_m = 0;
            @(posedge clock); #1;
            check({tag, " rst_rdy_m"}, int'(ready_out_LmR), 0);
            check({tag, " rst_state"}, int'(fsm_state), int'(CAPTURE));
            @(negedge clock);
            reset = 1'b0;
            return;
        end
        @(posedge clock); #1;                       // LmR out
        check({tag, " rdy_m"}, int'(ready_out_LmR), 1);
        check({tag, " rdy_p_e3"}, int'(ready_out_LpR), 0);
        check({tag, " lmr"}, int'(LI_in_LmR), exp_m);
        check({tag, " hold_p_e3"}, int'(LI_in_LpR), exp_p);
        last_m = exp_m;
        @(posedge clock); #1;                       // idle
        check({tag, " rdy_p_e4"}, int'(ready_out_LpR), 0);
        check({tag, " rdy_m_e4"}, int'(ready_out_LmR), 0);
        check({tag, " st_idle"}, int'(fsm_state), int'(IDLE));
        repeat (SP - 5) @(posedge clock);
        @(negedge clock);
        check({tag, " hold_m_end"}, int'(LI_in_LmR), exp_m);
        check({tag, " st_cap"}, int'(fsm_state), int'(CAPTURE));
    endtask

    // Directed sequence
    initial begin
        checks = 0;
        errors = 0;
        last_p = 0;
        last_m = 0;
        reset  = 1'b1;
        LEFT   = '0;
        RIGHT  = '0;
        Ks     = '0;
        Kd     = '0;
        repeat (2) @(negedge clock);
        check("reset lpr", int'(LI_in_LpR), 0);
        check("reset lmr", int'(LI_in_LmR), 0);
        check("reset rdy_p", int'(ready_out_LpR), 0);
        check("reset rdy_m", int'(ready_out_LmR), 0);
        check("reset state", int'(fsm_state), int'(CAPTURE));
        reset = 1'b0;

        // 47*8/16 = 23.5 -> 23 ; -17*12/16 = -12.75 -> -13
        run_sample("basic", 15, 32, 8, 12, 23, -13, 1'b0, 1'b0);
        // 45*8/16 = 22.5 -> 22 ; -5*12/16 = -3.75 -> -4
        run_sample("floor", 20, 25, 8, 12, 22, -4, 1'b0, 1'b0);
        // 262142*15/16 saturates high ; difference is zero
        run_sample("sat_hi", 131071, 131071, 15, 12, 131071, 0, 1'b0, 1'b0);
        // -1*15/16 -> -1 ; -262143*15/16 saturates low
        run_sample("sat_lo", -131072, 131071, 15, 15, -1, -131072, 1'b0, 1'b0);
        // zero factors force zero on both paths
        run_sample("k_zero", 5000, -3000, 0, 0, 0, 0, 1'b0, 1'b0);
        // inputs moved after capture are ignored: 40*8/16 = 20 ; 160*12/16 = 120
        run_sample("ignore", 100, -60, 8, 12, 20, 120, 1'b1, 1'b0);
        // reset between the two strobes aborts the difference result
        run_sample("abort", 15, 32, 8, 12, 23, -13, 1'b0, 1'b1);
        // cadence resumes right after release
        run_sample("resume", 20, 25, 8, 12, 22, -4, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_sf_48_withoutround.md
Name: block_sf_48_withoutround

Overview:
Stereo matrix and scale-factor stage of the all-digital FM modulator, running at the 48 kHz audio sample rate. Once per sample period it captures LEFT/RIGHT and forms the sum (L+R) and difference (L−R). Each result is scaled by a 4-bit scale factor using truncation (floor, no rounding), saturated to 18 bits, and handed to the downstream linear interpolators with one-cycle ready strobes. One multiplier is time-shared between the two paths, so the LpR and LmR results appear in consecutive cycles.

Parameters:
SAMPLE_PERIOD, 8, clock cycles per audio sample; legal values ≥ 4.
DW, 18, audio sample and output width (signed).
KW, 4, scale-factor width (unsigned).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
LEFT  input  18  signed left-channel sample.
RIGHT  input  18  signed right-channel sample.
Ks  input  4  unsigned sum scale factor, Q1.3 (8 = gain 1.0).
Kd  input  4  unsigned difference scale factor, Q1.3 (12 = gain 1.5).
LI_in_LpR  output  18  signed scaled (L+R)/2, held between updates.
LI_in_LmR  output  18  signed scaled (L−R)/2, held between updates.
ready_out_LpR  output  1  one-cycle strobe: LI_in_LpR is new.
ready_out_LmR  output  1  one-cycle strobe: LI_in_LmR is new.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset (async, active-high) sets:
  - the phase counter, all pipeline registers, both outputs and both readies to 0;
  - the FSM to CAPTURE.
- Phase counter cnt runs 0..SAMPLE_PERIOD−1 and wraps. It free-runs from the first rising edge after reset deasserts.
- cnt==0 (CAPTURE):
  - register LEFT, RIGHT, Ks, Kd;
  - s = LEFT+RIGHT and d = LEFT−RIGHT, both 19-bit signed, no overflow.
  - Inputs are ignored in all other phases.
- cnt==1 (MUL_P): p = s × {0,Ks}. Signed 19×5 product, 24-bit, registered.
- cnt==2 (OUT_P):
  - LI_in_LpR <= sat18(p >>> 4); ready_out_LpR = 1 for this cycle only;
  - multiplier computes m = d × {0,Kd}.
- cnt==3 (OUT_M): LI_in_LmR <= sat18(m >>> 4); ready_out_LmR = 1 for this cycle only.
- cnt ≥ 4: idle; outputs hold, readies are 0.
- Arithmetic: the >>>4 combines /2 (matrix) and /8 (Q1.3), as an arithmetic shift, i.e. floor toward −∞. There is no rounding term.
- sat18 clamps to [−131072, 131071].
- Latency: capture edge to LpR valid is 2 cycles; to LmR valid is 3 cycles. The two readies are never high simultaneously.
- Boundaries:
  - Ks=0 or Kd=0 gives 0 on that path.
  - Full-scale inputs with K=15 saturate.
  - Reset mid-sequence aborts it: outputs return to 0 immediately, and the next capture is at cnt==0 after release.
  - Outputs update only on their ready cycle.

Decomposition:
- Package sf48_pkg holds: DW=18, KW=4, SUMW=19, PRODW=24, SHIFT=4, SAT_MAX=131071, SAT_MIN=−131072, and the FSM state enum {CAPTURE, MUL_P, OUT_P, OUT_M, IDLE}.
- One sub-module, sf_scale_trunc: a combinational 19-bit signed × 4-bit unsigned multiply, then >>>4 and saturate to 18 bits. It is instantiated once, with its operands muxed between s/Ks and d/Kd.

Test Plan:
1. Reset, then LEFT=15, RIGHT=32, Ks=8, Kd=12 → LI_in_LpR=23 with ready_out_LpR; next cycle LI_in_LmR=−13 with ready_out_LmR. Readies never overlap.
2. Next sample: LEFT=20, RIGHT=25 (same K) → LpR=22 (22.5 truncated), LmR=−4 (−3.75 floored). This confirms floor, not round.
3. LEFT=RIGHT=131071, Ks=15 → LpR=131071 (saturated), LmR=0. Then LEFT=−131072, RIGHT=131071, Kd=15 → LmR=−131072.
4. Ks=0, Kd=0 with any inputs → both outputs 0, and readies still strobe once per SAMPLE_PERIOD.
5. Change LEFT/RIGHT/Ks/Kd at cnt=1..3 → results reflect only the values captured at cnt==0.
6. Assert reset between ready_out_LpR and ready_out_LmR → outputs go to 0 asynchronously, no LmR strobe for that sample, and normal cadence resumes after release.
